// File: rtl/lemv8_pkg.sv
// Shared LEGv8 execute-stage encodings: ALUOp, forwarding selects, opcodes and
// the pipeline-controller state type.
package lemv8_pkg;

    localparam int unsigned REG_W_DEF = 5;
    localparam int unsigned OPC_W_DEF = 11;
    localparam logic [4:0]  XZR_IDX   = 5'd31;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_PASSB = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } ctrl_state_e;

    // Opcodes as seen by the decoder (CBZ is an 8-bit opcode, low bits zero).
    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OP_CBZ  = 11'b101_1010_0000;

endpackage

// File: rtl/ex_pipe_ctrl_if.sv
// Decode-side and execute-side signals of the execute-stage pipeline controller.
interface ex_pipe_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned OPC_W = 11
);
    logic             id_valid;
    logic             id_ready;
    logic [OPC_W-1:0] id_opcode;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic [REG_W-1:0] id_rd;
    logic [1:0]       id_alu_op;
    logic             id_alu_src;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_reg_write;
    logic             id_branch;
    logic             ex_zero;
    logic             mem_stall;
    logic             ex_valid;
    logic [OPC_W-1:0] ex_opcode;
    logic [1:0]       ex_alu_op;
    logic             ex_alu_src;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_reg_write;
    logic             ex_branch;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             pc_src;
    logic             flush;

    modport master (
        output id_valid, id_opcode, id_rn, id_rm, id_rd, id_alu_op, id_alu_src,
               id_mem_read, id_mem_write, id_reg_write, id_branch, ex_zero, mem_stall,
        input  id_ready, ex_valid, ex_opcode, ex_alu_op, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_branch, fwd_a, fwd_b, pc_src, flush
    );

    modport slave (
        input  id_valid, id_opcode, id_rn, id_rm, id_rd, id_alu_op, id_alu_src,
               id_mem_read, id_mem_write, id_reg_write, id_branch, ex_zero, mem_stall,
        output id_ready, ex_valid, ex_opcode, ex_alu_op, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_reg_write, ex_branch, fwd_a, fwd_b, pc_src, flush
    );
endinterface

// File: rtl/ex_pipe_ctrl_fwd_unit.sv
// Combinational ALU operand forwarding compare; EX/MEM result wins over MEM/WB.
module fwd_unit
    import lemv8_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter logic [REG_W-1:0] XZR = REG_W'(31)
) (
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [REG_W-1:0] ex_rn,
    input  logic [REG_W-1:0] ex_rm,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);
    logic mem_hit_ok;
    logic wb_hit_ok;

    assign mem_hit_ok = mem_valid & mem_reg_write & (mem_rd != XZR);
    assign wb_hit_ok  = wb_valid & wb_reg_write & (wb_rd != XZR);

    always_comb begin
        fwd_a = FWD_RF;
        if (mem_hit_ok && (mem_rd == ex_rn)) begin
            fwd_a = FWD_MEM;
        end else if (wb_hit_ok && (wb_rd == ex_rn)) begin
            fwd_a = FWD_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (mem_hit_ok && (mem_rd == ex_rm)) begin
            fwd_b = FWD_MEM;
        end else if (wb_hit_ok && (wb_rd == ex_rm)) begin
            fwd_b = FWD_WB;
        end
    end
endmodule

// File: rtl/ex_pipe_ctrl.sv
// LEGv8 execute-stage pipeline controller: ID/EX control register, EX/MEM/WB
// destination tracking, forwarding, load-use bubbles and taken-CBZ flushes.
module ex_pipe_ctrl
    import lemv8_pkg::*;
#(
    parameter int unsigned      REG_W        = 5,
    parameter int unsigned      OPC_W        = 11,
    parameter logic [REG_W-1:0] XZR          = REG_W'(31),
    parameter int unsigned      FLUSH_CYCLES = 1
) (
    input logic           clk,
    input logic           rst_n,
    ex_pipe_ctrl_if.slave bus
);
    typedef struct packed {
        logic             valid;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic [REG_W-1:0] rd;
        logic [1:0]       alu_op;
        logic             alu_src;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             branch;
    } ex_reg_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } track_t;

    ex_reg_t     ex_q, ex_d, id_instr;
    track_t      mem_q, wb_q;
    ctrl_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        taken, load_use, ready_raw, pc_src_c, flush_c;

    assign id_instr = '{valid: 1'b1, opcode: bus.id_opcode, rn: bus.id_rn, rm: bus.id_rm,
                        rd: bus.id_rd, alu_op: bus.id_alu_op, alu_src: bus.id_alu_src,
                        mem_read: bus.id_mem_read, mem_write: bus.id_mem_write,
                        reg_write: bus.id_reg_write, branch: bus.id_branch};

    assign taken    = ex_q.valid & ex_q.branch & bus.ex_zero;
    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != XZR) & bus.id_valid &
                      ((bus.id_rn == ex_q.rd) | (bus.id_rm == ex_q.rd));

    always_comb begin
        ex_d      = ex_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_raw = 1'b0;
        pc_src_c  = 1'b0;
        flush_c   = 1'b0;
        if (!bus.mem_stall) begin
            ex_d = '0;
            if (taken) begin
                pc_src_c  = 1'b1;
                flush_c   = 1'b1;
                ready_raw = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    cnt_d   = 2'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = RUN;
                end
            end else if (state_q == FLUSH) begin
                flush_c   = 1'b1;
                ready_raw = 1'b1;
                cnt_d     = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = RUN;
                end
            end else if (load_use) begin
                state_d = STALL;
            end else begin
                ready_raw = 1'b1;
                state_d   = RUN;
                if (bus.id_valid) begin
                    ex_d = id_instr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (!bus.mem_stall) begin
            ex_q    <= ex_d;
            mem_q   <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered state already clears on reset; id_ready alone is input-driven.
    assign bus.id_ready     = ready_raw & rst_n;
    assign bus.pc_src       = pc_src_c;
    assign bus.flush        = flush_c;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_opcode    = ex_q.opcode;
    assign bus.ex_alu_op    = ex_q.alu_op;
    assign bus.ex_alu_src   = ex_q.alu_src;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_branch    = ex_q.branch;

    fwd_unit #(
        .REG_W (REG_W),
        .XZR   (XZR)
    ) u_fwd (
        .mem_valid     (mem_q.valid),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_valid      (wb_q.valid),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_q.rd),
        .ex_rn         (ex_q.rn),
        .ex_rm         (ex_q.rm),
        .fwd_a         (bus.fwd_a),
        .fwd_b         (bus.fwd_b)
    );
endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Scoreboard bench for ex_pipe_ctrl: one instance with FLUSH_CYCLES=1, one with 2.
module tb_ex_pipe_ctrl;
    import lemv8_pkg::*;

    typedef struct packed {
        logic [10:0] opc;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic [1:0]  aop;
        logic        src;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        br;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   id_valid, ex_zero, mem_stall;
    instr_t cur;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    int          q_cyc[$];
    int          q_dut[$];
    logic [25:0] q_obs[$];
    string       q_name[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_pipe_ctrl_if bus1 ();
    ex_pipe_ctrl_if bus2 ();

    ex_pipe_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    ex_pipe_ctrl #(.FLUSH_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus1.id_valid = id_valid;      assign bus2.id_valid = id_valid;
    assign bus1.id_opcode = cur.opc;      assign bus2.id_opcode = cur.opc;
    assign bus1.id_rn = cur.rn;           assign bus2.id_rn = cur.rn;
    assign bus1.id_rm = cur.rm;           assign bus2.id_rm = cur.rm;
    assign bus1.id_rd = cur.rd;           assign bus2.id_rd = cur.rd;
    assign bus1.id_alu_op = cur.aop;      assign bus2.id_alu_op = cur.aop;
    assign bus1.id_alu_src = cur.src;     assign bus2.id_alu_src = cur.src;
    assign bus1.id_mem_read = cur.mr;     assign bus2.id_mem_read = cur.mr;
    assign bus1.id_mem_write = cur.mw;    assign bus2.id_mem_write = cur.mw;
    assign bus1.id_reg_write = cur.rw;    assign bus2.id_reg_write = cur.rw;
    assign bus1.id_branch = cur.br;       assign bus2.id_branch = cur.br;
    assign bus1.ex_zero = ex_zero;        assign bus2.ex_zero = ex_zero;
    assign bus1.mem_stall = mem_stall;    assign bus2.mem_stall = mem_stall;

    logic [25:0] obs1, obs2;
    assign obs1 = {bus1.ex_valid, bus1.ex_opcode, bus1.ex_alu_op, bus1.ex_alu_src,
                   bus1.ex_mem_read, bus1.ex_mem_write, bus1.ex_reg_write, bus1.ex_branch,
                   bus1.fwd_a, bus1.fwd_b, bus1.pc_src, bus1.flush, bus1.id_ready};
    assign obs2 = {bus2.ex_valid, bus2.ex_opcode, bus2.ex_alu_op, bus2.ex_alu_src,
                   bus2.ex_mem_read, bus2.ex_mem_write, bus2.ex_reg_write, bus2.ex_branch,
                   bus2.fwd_a, bus2.fwd_b, bus2.pc_src, bus2.flush, bus2.id_ready};

    function automatic instr_t rtype(input logic [10:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rn, input logic [4:0] rm);
        return '{opc: opc, rn: rn, rm: rm, rd: rd, aop: ALU_RTYPE, src: 1'b0,
                 mr: 1'b0, mw: 1'b0, rw: 1'b1, br: 1'b0};
    endfunction

    function automatic instr_t ldur(input logic [4:0] rd, input logic [4:0] rn);
        return '{opc: OP_LDUR, rn: rn, rm: 5'd0, rd: rd, aop: ALU_ADD, src: 1'b1,
                 mr: 1'b1, mw: 1'b0, rw: 1'b1, br: 1'b0};
    endfunction

    function automatic instr_t cbz(input logic [4:0] rt);
        return '{opc: OP_CBZ, rn: 5'd31, rm: rt, rd: 5'd31, aop: ALU_PASSB, src: 1'b0,
                 mr: 1'b0, mw: 1'b0, rw: 1'b0, br: 1'b1};
    endfunction

    function automatic logic [25:0] val(input instr_t t, input logic [1:0] fa,
                                        input logic [1:0] fb, input logic pc,
                                        input logic fl, input logic rdy);
        return {1'b1, t.opc, t.aop, t.src, t.mr, t.mw, t.rw, t.br, fa, fb, pc, fl, rdy};
    endfunction

    function automatic logic [25:0] bub(input logic pc, input logic fl, input logic rdy);
        return {1'b0, 18'd0, 2'b00, 2'b00, pc, fl, rdy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input instr_t t);
        id_valid = v;
        cur      = t;
    endtask

    task automatic expect_obs(input int which, input string name, input logic [25:0] o);
        q_cyc.push_back(cyc);
        q_dut.push_back(which);
        q_obs.push_back(o);
        q_name.push_back(name);
    endtask

    // Monitor: compare every expectation due in the current cycle, away from the edge.
    always @(negedge clk) begin
        logic [25:0] got;
        for (int i = q_cyc.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] <= cyc) begin
                got = (q_dut[i] == 2) ? obs2 : obs1;
                checks++;
                if (q_cyc[i] < cyc) begin
                    errors++;
                    $display("FAIL %s (dut%0d): expectation for cycle %0d never sampled",
                             q_name[i], q_dut[i], q_cyc[i]);
                end else if (got !== q_obs[i]) begin
                    errors++;
                    $display("FAIL %s (dut%0d cyc %0d): got %h required %h",
                             q_name[i], q_dut[i], cyc, got, q_obs[i]);
                end
                q_cyc.delete(i);
                q_dut.delete(i);
                q_obs.delete(i);
                q_name.delete(i);
            end
        end
    end

    instr_t add3, add4, sub7, add12, add31, add13, ld5, add6, cbz6, add14, cbz14, add15,
            cbz0, add16;

    initial begin
        add3  = rtype(OP_ADD, 5'd3, 5'd1, 5'd2);
        add4  = rtype(OP_ADD, 5'd4, 5'd3, 5'd3);
        sub7  = rtype(OP_SUB, 5'd7, 5'd8, 5'd9);
        add12 = rtype(OP_ADD, 5'd12, 5'd4, 5'd9);
        add31 = rtype(OP_ADD, 5'd31, 5'd1, 5'd2);
        add13 = rtype(OP_ADD, 5'd13, 5'd31, 5'd31);
        ld5   = ldur(5'd5, 5'd20);
        add6  = rtype(OP_ADD, 5'd6, 5'd5, 5'd1);
        cbz6  = cbz(5'd6);
        add14 = rtype(OP_ADD, 5'd14, 5'd1, 5'd2);
        cbz14 = cbz(5'd14);
        add15 = rtype(OP_ADD, 5'd15, 5'd1, 5'd2);
        cbz0  = cbz(5'd0);
        add16 = rtype(OP_ADD, 5'd16, 5'd1, 5'd2);

        rst_n = 1'b0; id_valid = 1'b0; cur = '0; ex_zero = 1'b0; mem_stall = 1'b0;

        step();  // 1
        expect_obs(1, "reset", bub(0, 0, 0));
        expect_obs(2, "reset", bub(0, 0, 0));
        step(); rst_n = 1'b1;  // 2
        expect_obs(1, "idle_ready", bub(0, 0, 1));
        step(); drive(1, add3);  // 3
        expect_obs(1, "add3_issue", bub(0, 0, 1));
        step(); drive(1, add4);  // 4
        expect_obs(1, "add3_in_ex", val(add3, 2'b00, 2'b00, 0, 0, 1));
        step(); drive(1, sub7);  // 5
        expect_obs(1, "fwd_exmem", val(add4, 2'b10, 2'b10, 0, 0, 1));
        step(); drive(1, add12);  // 6
        expect_obs(1, "independent", val(sub7, 2'b00, 2'b00, 0, 0, 1));
        step(); drive(1, add31);  // 7
        expect_obs(1, "fwd_memwb", val(add12, 2'b01, 2'b00, 0, 0, 1));
        step(); drive(1, add13);  // 8
        expect_obs(1, "rd_xzr_issue", val(add31, 2'b00, 2'b00, 0, 0, 1));
        step(); drive(1, ld5);  // 9
        expect_obs(1, "xzr_no_fwd", val(add13, 2'b00, 2'b00, 0, 0, 1));
        step(); drive(1, add6);  // 10
        expect_obs(1, "load_use", val(ld5, 2'b00, 2'b00, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin  // 11..13
            step(); mem_stall = 1'b1;
            expect_obs(1, "mem_stall_hold", bub(0, 0, 0));
        end
        step(); mem_stall = 1'b0;  // 14
        expect_obs(1, "stall_release", bub(0, 0, 1));
        step(); drive(1, cbz6);  // 15
        expect_obs(1, "use_after_load", val(add6, 2'b01, 2'b00, 0, 0, 1));
        step(); drive(1, add14); ex_zero = 1'b1;  // 16
        expect_obs(1, "cbz_taken", val(cbz6, 2'b00, 2'b10, 1, 1, 1));
        expect_obs(2, "cbz_taken", val(cbz6, 2'b00, 2'b10, 1, 1, 1));
        step();  // 17
        expect_obs(1, "bubble_no_fire", bub(0, 0, 1));
        expect_obs(2, "flush_extra", bub(0, 1, 1));
        step(); ex_zero = 1'b0; drive(1, cbz14);  // 18
        expect_obs(1, "after_flush", val(add14, 2'b00, 2'b00, 0, 0, 1));
        expect_obs(2, "flush_done", bub(0, 0, 1));
        step(); drive(1, add15);  // 19
        expect_obs(1, "cbz_not_taken", val(cbz14, 2'b00, 2'b10, 0, 0, 1));
        step(); drive(1, cbz0);  // 20
        expect_obs(1, "add15_in_ex", val(add15, 2'b00, 2'b00, 0, 0, 1));
        step(); ex_zero = 1'b1; drive(1, add16);  // 21
        expect_obs(1, "cbz_taken2", val(cbz0, 2'b00, 2'b00, 1, 1, 1));
        expect_obs(2, "cbz_taken2", val(cbz0, 2'b00, 2'b00, 1, 1, 1));
        step(); rst_n = 1'b0;  // 22: between edges, mid-FLUSH for dut2
        expect_obs(1, "async_reset", bub(0, 0, 0));
        expect_obs(2, "async_reset", bub(0, 0, 0));
        step(); rst_n = 1'b1; ex_zero = 1'b0;  // 23
        expect_obs(1, "post_reset", bub(0, 0, 1));
        expect_obs(2, "post_reset", bub(0, 0, 1));
        step(); drive(0, '0);  // 24
        expect_obs(2, "run_after_reset", val(add16, 2'b00, 2'b00, 0, 0, 1));
        step();
        step();
        if (q_cyc.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q_cyc.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
